// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared helpers for the round-robin arbitrated mux
// Purpose: modulo-N index increment and the reset value of the last-grant pointer.
// Ports: none (package).
package rr_arb_pkg;

    // Modulo-n increment without a divider: idx is always in [0, n-1].
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

    // The pointer resets to the last channel so that channel 0 is searched first.
    function automatic int last_grant_rst(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_n_if.sv
// rtl/rr_arb_mux_n_if.sv - producer/consumer handshake bundle for rr_arb_mux_n
// Purpose: groups the N request channels and the single output channel.
// Signals:
//   in_valid  [N]        per-channel request
//   in_data   [N*WIDTH]  flattened words, channel i at [i*WIDTH +: WIDTH]
//   in_ready  [N]        per-channel accept, at most one bit high
//   out_valid            output register holds a word
//   out_data  [WIDTH]    registered selected word
//   out_src   [SW]       channel that supplied out_data
//   out_ready            consumer accepts out_data
// Modports: slave = arbiter side, master = producers/consumer side.
interface rr_arb_mux_n_if #(
    parameter int WIDTH = 64,
    parameter int N     = 4
);
    localparam int SW = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_src;
    logic               out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_src
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_src
    );

endinterface

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - combinational N-way round-robin grant
// Purpose: picks the first requester at or after (last_grant+1) mod N, wrapping.
// Ports:
//   req        [N]   requests
//   last_grant [SW]  channel granted on the most recent transfer
//   en               grant allowed this cycle; grant is zero when low
//   grant      [N]   one-hot grant or zero
module rr_arbiter_n
    import rr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last_grant,
    input  logic                 en,
    output logic [N-1:0]         grant
);
    localparam int SW = $clog2(N);

    int   cur;
    logic found;

    // Walk the N candidates in priority order; the first hit wins and
    // masks every later candidate, which keeps the grant one-hot.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cur   = int'(last_grant);
        for (int k = 0; k < N; k++) begin
            cur = next_idx(cur, N);
            if (en && !found && req[SW'(cur)]) begin
                grant[SW'(cur)] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux_n.sv
// rtl/rr_arb_mux_n.sv - N-channel round-robin arbitrated mux with registered output
// Purpose: selects one of N valid/ready producers per cycle in round-robin order
//          and registers the chosen word for a single consumer.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    rr_arb_mux_n_if.slave (in_valid/in_data/in_ready, out_valid/out_data/out_src/out_ready)
// Parameters: WIDTH data width (>=1), N channel count (>=2).
module rr_arb_mux_n
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           reset,
    rr_arb_mux_n_if.slave  bus
);
    localparam int            SW       = $clog2(N);
    localparam logic [SW-1:0] LAST_RST = SW'(last_grant_rst(N));

    generate
        if (N < 2) begin : g_bad_n
            $error("rr_arb_mux_n: N must be at least 2");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("rr_arb_mux_n: WIDTH must be at least 1");
        end
    endgenerate

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SW-1:0]    r_out_src;
    logic [SW-1:0]    r_last_grant;

    logic             w_load;
    logic [N-1:0]     w_grant;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;
    logic [SW-1:0]    w_sel_src;

    // The output register can take a new word when it is empty or being drained.
    assign w_load = !r_out_valid || bus.out_ready;

    rr_arbiter_n #(
        .N (N)
    ) u_arb (
        .req        (bus.in_valid),
        .last_grant (r_last_grant),
        .en         (w_load),
        .grant      (w_grant)
    );

    // A grant is only issued to a requesting channel while loading, so any
    // grant bit is a completed handshake.
    assign w_xfer = |w_grant;

    // AND-OR select: grant is one-hot or zero, so OR-ing masked words and
    // indices yields the granted channel without a priority chain.
    always_comb begin
        w_sel_data = '0;
        w_sel_src  = '0;
        for (int i = 0; i < N; i++) begin
            w_sel_data = w_sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
            w_sel_src  = w_sel_src  | (w_grant[i] ? SW'(i) : '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_src    <= '0;
            r_last_grant <= LAST_RST;
        end else if (w_xfer) begin
            // Covers both an empty register and drain-plus-refill in one edge.
            r_out_valid  <= 1'b1;
            r_out_data   <= w_sel_data;
            r_out_src    <= w_sel_src;
            r_last_grant <= w_sel_src;
        end else if (w_load) begin
            // Drained with nothing to replace it; data/src keep their last values.
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.in_ready  = w_grant;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_rr_arb_mux_n.sv
// tb/tb_rr_arb_mux_n.sv - self-checking bench for rr_arb_mux_n
module tb_rr_arb_mux_n;
    localparam int W  = 64;
    localparam int N  = 4;
    localparam int W3 = 8;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rr_arb_mux_n_if #(.WIDTH(W),  .N(N))  bus ();
    rr_arb_mux_n_if #(.WIDTH(W3), .N(N3)) bus3 ();

    rr_arb_mux_n #(.WIDTH(W),  .N(N))  dut  (.clk(clk), .reset(rst), .bus(bus));
    rr_arb_mux_n #(.WIDTH(W3), .N(N3)) dut3 (.clk(clk), .reset(rst), .bus(bus3));

    int checks = 0;
    int errors = 0;

    // Reference model: the output register contents and the pointer, as plain values.
    bit           m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_src   = 0;
    int           m_last  = N - 1;
    logic [N-1:0] m_gnt   = '0;
    logic [N-1:0] m_want;
    bit           m_load;
    bit           m_found;
    int           m_pick;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int c, input logic [63:0] d);
        bus.in_data[c*W +: W] = d;
    endtask

    // Compare process: at every falling edge check the registered outputs and
    // the accept vector, then advance the model to the state after the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_src   = 0;
            m_last  = N - 1;
            m_gnt   = '0;
            chk("m_rst_valid", 64'(bus.out_valid), 64'(0));
            chk("m_rst_data",  64'(bus.out_data),  64'(0));
        end else begin
            chk("m_valid", 64'(bus.out_valid), 64'(m_valid));
            chk("m_data",  64'(bus.out_data),  64'(m_data));
            chk("m_src",   64'(bus.out_src),   64'(m_src));
            m_load  = !m_valid || bus.out_ready;
            m_want  = '0;
            m_found = 1'b0;
            m_pick  = 0;
            if (m_load) begin
                for (int k = 1; k <= N; k++) begin
                    if (!m_found && bus.in_valid[(m_last + k) % N]) begin
                        m_pick  = (m_last + k) % N;
                        m_found = 1'b1;
                    end
                end
            end
            if (m_found) m_want[m_pick] = 1'b1;
            chk("m_in_ready", 64'(bus.in_ready), 64'(m_want));
            m_gnt = m_want;
            if (m_found) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[m_pick*W +: W];
                m_src   = m_pick;
                m_last  = m_pick;
            end else if (m_load) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        bus.in_valid   = '0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus3.in_valid  = '0;
        bus3.in_data   = '0;
        bus3.out_ready = 1'b0;
        #1 rst = 1'b1;

        // Reset priority, with the 3-channel/8-bit instance running alongside.
        bus.in_valid = 4'hF;
        for (int c = 0; c < N; c++) set_word(c, 64'hA0 + 64'(c));
        bus.out_ready  = 1'b1;
        bus3.in_valid  = 3'b111;
        bus3.in_data   = {8'h33, 8'h22, 8'h11};
        bus3.out_ready = 1'b1;
        step;
        step;
        chk("rst_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_data",  64'(bus.out_data),  64'(0));
        chk("rst_src",   64'(bus.out_src),   64'(0));
        chk("rst3_valid", 64'(bus3.out_valid), 64'(0));
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step;
            chk("rp_valid", 64'(bus.out_valid), 64'(1));
            chk("rp_src",   64'(bus.out_src),   64'(k % 4));
            chk("rp_data",  64'(bus.out_data),  64'hA0 + 64'(k % 4));
            chk("sc_src",   64'(bus3.out_src),  64'(k % 3));
            chk("sc_data",  64'(bus3.out_data), 64'(((k % 3) + 1) * 8'h11));
        end

        // Backpressure: ch2 delivers 0x55, then the consumer stalls for 3 cycles.
        bus.in_valid = 4'b0100;
        set_word(2, 64'h55);
        step;
        chk("bp_src",  64'(bus.out_src),  64'(2));
        chk("bp_data", 64'(bus.out_data), 64'h55);
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
            step;
            chk("bp_hold_valid", 64'(bus.out_valid), 64'(1));
            chk("bp_hold_data",  64'(bus.out_data),  64'h55);
            chk("bp_hold_src",   64'(bus.out_src),   64'(2));
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rel_ready", 64'(bus.in_ready), 64'(4'b1000));
        step;
        chk("bp_next_src",  64'(bus.out_src),  64'(3));
        chk("bp_next_data", 64'(bus.out_data), 64'hA3);

        // Drain with no requests.
        bus.in_valid = 4'b0001;
        set_word(0, 64'h77);
        step;
        chk("dr_fill_data", 64'(bus.out_data), 64'h77);
        bus.in_valid = 4'b0000;
        step;
        chk("dr_valid", 64'(bus.out_valid), 64'(0));
        chk("dr_data",  64'(bus.out_data),  64'h77);
        chk("dr_src",   64'(bus.out_src),   64'(0));
        bus.in_valid = 4'hF;
        #1;
        chk("dr_last_kept", 64'(bus.in_ready), 64'(4'b0010));

        // Sparse: channels 1 and 3 only, starting from last_grant=1.
        bus.in_valid = 4'b0010;
        set_word(1, 64'h11);
        set_word(3, 64'h33);
        step;
        chk("sp_first_src", 64'(bus.out_src), 64'(1));
        bus.in_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("sp_ready0", 64'(bus.in_ready[0]), 64'(0));
            chk("sp_ready2", 64'(bus.in_ready[2]), 64'(0));
            step;
            chk("sp_src",  64'(bus.out_src),  64'((k % 2 == 0) ? 3 : 1));
            chk("sp_data", 64'(bus.out_data), (k % 2 == 0) ? 64'h33 : 64'h11);
        end

        // Async reset while a word is held.
        bus.in_valid = 4'hF;
        for (int c = 0; c < N; c++) set_word(c, 64'hA0 + 64'(c));
        step;
        chk("as_pre_valid", 64'(bus.out_valid), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("as_valid", 64'(bus.out_valid), 64'(0));
        chk("as_data",  64'(bus.out_data),  64'(0));
        step;
        step;
        rst = 1'b0;
        step;
        chk("as_src",  64'(bus.out_src),  64'(0));
        chk("as_data2", 64'(bus.out_data), 64'hA0);

        // Randomized traffic; producers hold a request until the model says it was taken.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step;
            for (int c = 0; c < N; c++) begin
                if (!bus.in_valid[c] || m_gnt[c]) begin
                    bus.in_valid[c] = ($urandom_range(0, 99) < 60);
                    set_word(c, {$urandom, $urandom});
                end
            end
            bus.out_ready = ($urandom_range(0, 99) < 70);
            if (cyc % 1000 == 999) begin
                #2 rst = 1'b1;
                step;
                rst = 1'b0;
            end
        end
        step;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux_n.md
Name: rr_arb_mux_n

Overview:
- Parametrised N-channel, WIDTH-bit selector with round-robin arbitration and a registered output stage.
- Generalises the fixed 64-bit 2:1 select: the select is derived internally from requester valids, not driven externally.
- Sits between multiple producers (e.g. memory/forwarding sources) and a single consumer.
- Valid/ready handshake on every channel; one transfer per cycle sustained.

Parameters:
- WIDTH, 64, data word width in bits (>= 1).
- N, 4, number of input channels (>= 2; elaboration error otherwise).
- SW, $clog2(N), width of source index (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel request; bit i belongs to channel i.
- in_data  input  N*WIDTH  flattened words; channel i at [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; at most one bit high per cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered selected word.
- out_src  output  SW  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_src=0, last_grant=N-1, so channel 0 has top priority on the first arbitration.
- load = !out_valid || out_ready. Computed combinationally each cycle.
- Grant: the first channel with in_valid=1, searching from (last_grant+1) mod N upward with wrap-around. Grant is one-hot or zero.
- in_ready[i] = load && grant[i]. No in_ready bit depends on in_valid of its own channel beyond arbitration. No bit is high when load=0.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. At the next rising edge:
  - out_data <= word i
  - out_src <= i
  - out_valid <= 1
  - last_grant <= i
- Consumer drains with no new grant (load=1, no in_valid): out_valid <= 0. out_data and out_src hold their last values.
- Simultaneous drain and new accept: the register is overwritten in the same edge, out_valid stays 1, and there is no bubble.
- Stall (out_valid=1, out_ready=0): out_data and out_src stay stable, all in_ready=0, last_grant frozen.
- Latency: 1 cycle from accepted input to out_valid. Throughput: 1 word per cycle.
- Fairness: a continuously requesting channel is granted within N transfers.
- last_grant advances only on an actual transfer, never on idle cycles.
- Producers must hold in_valid and in_data until accepted. The block does not check this.
- A reset asserted mid-transfer discards the held word immediately: out_valid goes to 0 asynchronously.
- No combinational path from out_ready to out_data or out_valid. There is a combinational path from out_ready to in_ready by design.

Decomposition:
- Package rr_arb_pkg holds:
  - function next_idx(idx, N) for modulo-N increment.
  - the reset constant for last_grant (N-1).
- Sub-module rr_arbiter_n (parameter N), purely combinational:
  - inputs: req[N], last_grant[SW], en
  - output: grant[N] one-hot
  - rr_arb_mux_n instantiates it once.
- The data select is an AND-OR reduction over grant. The existing 2:1 64-bit select cell is not reused, because N is arbitrary.

Test Plan:
- Reset priority: reset, then in_valid=4'b1111, channel data 0xA0..0xA3, out_ready=1. Required: out_src sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0, with no bubbles.
- Sparse requests: only channels 1 and 3 valid, last_grant=1. Required: grant ch3, then ch1, then ch3, alternating. in_ready[0] and in_ready[2] never high.
- Backpressure: deliver a word from ch2 (data 0x55), then hold out_ready=0 for 3 cycles with all channels valid. Required: out_data=0x55, out_src=2, out_valid=1 held stable, in_ready=0000 throughout. After release, next grant is ch3.
- Drain with no requests: out_valid=1 holding 0x77, in_valid=0000, out_ready=1. Required: out_valid=0 after the edge, out_data still 0x77, last_grant unchanged.
- Async reset mid-stream: assert reset between edges while out_valid=1. Required: out_valid=0, out_data=0 immediately, before the next edge. After release, ch0 wins with all channels valid.
- Width/count scaling: rebuild with WIDTH=8, N=3, all channels valid, data 0x11/0x22/0x33. Required: out_src 0,1,2,0 wraps correctly, and out_data matches each word exactly.
